out_mem_drain: RTL

//  Downstream readback stage of the NPU conv top. After conv done, reads NUM_WORDS results from the output

---
 rtl/npu_pkg.sv | 12 +
 rtl/drain_fifo.sv | 50 +++++
 rtl/out_mem_drain.sv | 136 +++++++++++++
 3 files changed

// File: rtl/npu_pkg.sv
// Shared NPU definitions: drain FSM encoding and default widths.
package npu_pkg;
  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_FIN   = 2'd3
  } drain_st_e;
endpackage

// File: rtl/drain_fifo.sv
// Synchronous FIFO with occupancy count; depth must be a power of two >= 2.
module drain_fifo #(
  parameter int W  = 33,
  parameter int D  = 4,
  parameter int CW = $clog2(D) + 1
) (
  input  logic          i_clk,
  input  logic          i_resetn,
  input  logic          i_push,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_pop,
  output logic [W-1:0]  o_rdata,
  output logic          o_empty,
  output logic          o_full,
  output logic [CW-1:0] o_count
);
  localparam int AW = $clog2(D);

  logic [W-1:0]  r_mem [D];
  logic [AW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt;
  logic          w_wr, w_rd;

  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == CW'(D));
  assign o_count = r_cnt;
  assign o_rdata = r_mem[r_rp];
  assign w_wr    = i_push & ~o_full;
  assign w_rd    = i_pop & ~o_empty;

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wp] <= i_wdata;
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp + AW'(1);
      if (w_rd) r_rp <= r_rp + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

// File: rtl/out_mem_drain.sv
// Output-memory readback: credit-gated B-port reads into a FIFO, streamed out with last.
// Optional DRAIN_CHECKSUM_EN adds o_checksum (sum of accepted beats).
module out_mem_drain
  import npu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = 1,
  parameter int FIFO_D = 4
) (
  input  logic              i_clk,
  input  logic              i_resetn,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [ADDR_W-1:0] i_num_words,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_mem_enb,
  output logic              o_mem_web,
  output logic [ADDR_W-1:0] o_mem_addrb,
`ifdef DRAIN_CHECKSUM_EN
  output logic [DATA_W-1:0] o_checksum,
`endif
  input  logic [DATA_W-1:0] i_mem_doutb,
  output logic [DATA_W-1:0] o_m_tdata,
  output logic              o_m_tvalid,
  input  logic              i_m_tready,
  output logic              o_m_tlast
);
  localparam int CW  = ADDR_W + 1;
  localparam int FCW = $clog2(FIFO_D) + 1;
  localparam logic [FCW:0] L_FD = (FCW+1)'(FIFO_D);

  drain_st_e       r_state, w_nxt;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [CW-1:0]   r_num, r_issued, r_returned, r_accepted;
  logic [FCW-1:0]  r_inflight, w_fcount;
  logic [RD_LAT:1] r_vld_pipe;
  logic            r_done;
  logic            w_start_acc, w_credit, w_issue, w_ret, w_beat, w_last_in;
  logic            w_fempty, w_ffull;
  logic [DATA_W:0] w_head;

  assign w_start_acc = i_start & ~o_busy;
  // Reserve a FIFO slot for every read still in the latency pipe.
  assign w_credit    = ({1'b0, w_fcount} + {1'b0, r_inflight}) < L_FD;
  assign w_issue     = (r_state == S_RUN) && (r_issued != r_num) && w_credit;
  assign w_ret       = r_vld_pipe[RD_LAT];
  assign w_last_in   = (r_returned + CW'(1) == r_num);
  assign w_beat      = o_m_tvalid & i_m_tready;

  assign o_busy      = (r_state != S_IDLE) | r_done;
  assign o_done      = r_done;
  assign o_mem_enb   = w_issue;
  assign o_mem_web   = 1'b0;
  assign o_mem_addrb = r_rd_ptr;
  assign o_m_tvalid  = ~w_fempty;
  assign o_m_tdata   = w_head[DATA_W-1:0];
  assign o_m_tlast   = w_head[DATA_W] & ~w_fempty;

  drain_fifo #(.W(DATA_W + 1), .D(FIFO_D), .CW(FCW)) u_fifo (
    .i_clk    (i_clk),
    .i_resetn (i_resetn),
    .i_push   (w_ret),
    .i_wdata  ({w_last_in, i_mem_doutb}),
    .i_pop    (w_beat),
    .o_rdata  (w_head),
    .o_empty  (w_fempty),
    .o_full   (w_ffull),
    .o_count  (w_fcount)
  );

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start_acc) w_nxt = (i_num_words == '0) ? S_FIN : S_RUN;
      S_RUN:   if (w_issue && (r_issued + CW'(1) == r_num)) w_nxt = S_FLUSH;
      // The final accepted beat leaves the FIFO empty with nothing in flight.
      S_FLUSH: if (w_beat && (r_accepted + CW'(1) == r_num)) w_nxt = S_FIN;
      S_FIN:   w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state    <= S_IDLE;
      r_done     <= 1'b0;
      r_rd_ptr   <= '0;
      r_num      <= '0;
      r_issued   <= '0;
      r_returned <= '0;
      r_accepted <= '0;
      r_inflight <= '0;
      r_vld_pipe <= '0;
    end else begin
      r_state <= w_nxt;
      r_done  <= (r_state == S_FIN);
      if (w_start_acc) begin
        r_rd_ptr   <= i_base_addr;
        r_num      <= {1'b0, i_num_words};
        r_issued   <= '0;
        r_returned <= '0;
        r_accepted <= '0;
      end else begin
        if (w_issue) begin
          r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
          r_issued <= r_issued + CW'(1);
        end
        if (w_ret)  r_returned <= r_returned + CW'(1);
        if (w_beat) r_accepted <= r_accepted + CW'(1);
      end
      case ({w_issue, w_ret})
        2'b10:   r_inflight <= r_inflight + FCW'(1);
        2'b01:   r_inflight <= r_inflight - FCW'(1);
        default: r_inflight <= r_inflight;
      endcase
      r_vld_pipe[1] <= w_issue;
      for (int i = 2; i <= RD_LAT; i++) r_vld_pipe[i] <= r_vld_pipe[i-1];
    end
  end

`ifdef DRAIN_CHECKSUM_EN
  logic [DATA_W-1:0] r_csum;
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn)        r_csum <= '0;
    else if (w_start_acc) r_csum <= '0;
    else if (w_beat)      r_csum <= r_csum + o_m_tdata;
  end
  assign o_checksum = r_csum;
`else
  // No checksum datapath in this build.
`endif

  a_push_not_full: assert property (@(posedge i_clk) disable iff (!i_resetn) w_ret |-> !w_ffull);
endmodule
